// File: rtl/modn_counter_prog.sv
// modn_counter_prog: runtime-programmable mod-N up/down counter with wrap/saturate and terminal-count pulse
module modn_counter_prog #(
  parameter int WIDTH       = 4,
  parameter int DEFAULT_MOD = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_down,
  input  logic             sat_mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             mod_wr,
  input  logic [WIDTH-1:0] mod_in,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             at_limit,
  output logic             load_err
);
  logic [WIDTH-1:0] count_q, count_d, mod_q, mod_d, lim;
  logic             tc_q, tc_d, load_err_q, load_err_d;
  assign lim      = mod_q - WIDTH'(1);
  assign count    = count_q;
  assign tc       = tc_q;
  assign load_err = load_err_q;
  assign at_limit = up_down ? (count_q == lim) : (count_q == '0);
  always_comb begin
    count_d    = count_q;
    mod_d      = mod_q;
    tc_d       = 1'b0;
    load_err_d = load_err_q;
    if (mod_wr) begin
      mod_d   = (mod_in < WIDTH'(2)) ? WIDTH'(2) : mod_in;
      count_d = (count_q >= mod_d) ? '0 : count_q;
    end else if (load) begin
      count_d    = (load_val >= mod_q) ? lim : load_val;
      load_err_d = load_err_q | (load_val >= mod_q);
    end else if (en) begin
      // at the limit: wrap (with tc) unless saturating, which holds
      if (at_limit) begin
        count_d = sat_mode ? count_q : (up_down ? '0 : lim);
        tc_d    = ~sat_mode;
      end else begin
        count_d = up_down ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q    <= '0;
      mod_q      <= WIDTH'(DEFAULT_MOD);
      tc_q       <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      mod_q      <= mod_d;
      tc_q       <= tc_d;
      load_err_q <= load_err_d;
    end
  end
endmodule
